// File: rtl/fifo_ref_checker.sv
// Purpose: synthesizable scoreboard running a cycle-accurate reference model of a snooped FIFO.
// Latency: obs outputs from edge k are judged at edge k+1; results are registered one edge later.
// Backpressure: none, passive observer; counters freeze once done is set.
module fifo_ref_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  obs_rst_n,
    input  logic                  obs_wr_en,
    input  logic                  obs_rd_en,
    input  logic [FIFO_WIDTH-1:0] obs_data_in,
    input  logic [FIFO_WIDTH-1:0] obs_data_out,
    input  logic                  obs_wr_ack,
    input  logic                  obs_overflow,
    input  logic                  obs_underflow,
    input  logic                  obs_full,
    input  logic                  obs_empty,
    input  logic                  obs_almostfull,
    input  logic                  obs_almostempty,
    input  logic                  test_finished,
    output logic                  cmp_valid,
    output logic                  mismatch,
    output logic [7:0]            mismatch_mask,
    output logic [7:0]            first_err_mask,
    output logic                  err_seen,
    output logic [CNT_W-1:0]      correct_count,
    output logic [CNT_W-1:0]      error_count,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef struct packed {
        logic almostempty;
        logic almostfull;
        logic empty;
        logic full;
        logic underflow;
        logic overflow;
        logic wr_ack;
    } flags_t;

    // Reference model state
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wp;
    logic [PTR_W-1:0]      rp;
    logic [CW-1:0]         cnt;
    logic [FIFO_WIDTH-1:0] m_data_out;
    logic                  m_wr_ack;
    logic                  m_overflow;
    logic                  m_underflow;
    flags_t                m_flags;
    flags_t                o_flags;

    logic wr_req;
    logic rd_req;
    logic do_wr;
    logic do_rd;
    logic armed;
    logic [7:0] diff;

    // Unknown request bits are treated as "no request" so the model never goes X.
    assign wr_req = (obs_wr_en === 1'b1);
    assign rd_req = (obs_rd_en === 1'b1);

    assign m_flags.full        = (cnt == CW'(FIFO_DEPTH));
    assign m_flags.empty       = (cnt == CW'(0));
    assign m_flags.almostfull  = (cnt == CW'(FIFO_DEPTH - 1));
    assign m_flags.almostempty = (cnt == CW'(1));
    assign m_flags.wr_ack      = m_wr_ack;
    assign m_flags.overflow    = m_overflow;
    assign m_flags.underflow   = m_underflow;

    // Full blocks the write and empty blocks the read, which yields read-only / write-only on collisions.
    assign do_wr = wr_req & ~m_flags.full;
    assign do_rd = rd_req & ~m_flags.empty;

    always_ff @(posedge clk) begin
        if (rst || (obs_rst_n == 1'b0)) begin
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            m_data_out  <= '0;
            m_wr_ack    <= 1'b0;
            m_overflow  <= 1'b0;
            m_underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wp <= wp + PTR_W'(1);
            end
            if (do_rd) begin
                m_data_out <= mem[rp];
                rp         <= rp + PTR_W'(1);
            end
            m_wr_ack    <= do_wr;
            m_overflow  <= wr_req & m_flags.full;
            m_underflow <= rd_req & m_flags.empty;
            cnt         <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (obs_rst_n == 1'b1) && do_wr) begin
            mem[wp] <= obs_data_in;
        end
    end

    assign o_flags.almostempty = obs_almostempty;
    assign o_flags.almostfull  = obs_almostfull;
    assign o_flags.empty       = obs_empty;
    assign o_flags.full        = obs_full;
    assign o_flags.underflow   = obs_underflow;
    assign o_flags.overflow    = obs_overflow;
    assign o_flags.wr_ack      = obs_wr_ack;

    // Case inequality so any unknown observed bit registers as a failure.
    always_comb begin
        diff    = '0;
        diff[0] = (obs_data_out !== m_data_out);
        diff[1] = (o_flags.wr_ack !== m_flags.wr_ack);
        diff[2] = (o_flags.overflow !== m_flags.overflow);
        diff[3] = (o_flags.underflow !== m_flags.underflow);
        diff[4] = (o_flags.full !== m_flags.full);
        diff[5] = (o_flags.empty !== m_flags.empty);
        diff[6] = (o_flags.almostfull !== m_flags.almostfull);
        diff[7] = (o_flags.almostempty !== m_flags.almostempty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed          <= 1'b0;
            cmp_valid      <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_mask  <= '0;
            first_err_mask <= '0;
            err_seen       <= 1'b0;
            correct_count  <= '0;
            error_count    <= '0;
            done           <= 1'b0;
        end else begin
            armed     <= 1'b1;
            cmp_valid <= armed;
            done      <= done | (test_finished === 1'b1);
            // done is the registered value, so a compare on the test_finished edge still counts.
            if (!done) begin
                if (armed) begin
                    mismatch      <= |diff;
                    mismatch_mask <= diff;
                    if (|diff) begin
                        if (error_count != '1) begin
                            error_count <= error_count + CNT_W'(1);
                        end
                        if (!err_seen) begin
                            first_err_mask <= diff;
                            err_seen       <= 1'b1;
                        end
                    end else if (correct_count != '1) begin
                        correct_count <= correct_count + CNT_W'(1);
                    end
                end else begin
                    mismatch      <= 1'b0;
                    mismatch_mask <= '0;
                end
            end else begin
                mismatch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ref_checker.sv
// Directed bench: drives observed FIFO traffic by hand and checks the checker's verdicts and counters.
module tb_fifo_ref_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        obs_rst_n;
    logic        obs_wr_en;
    logic        obs_rd_en;
    logic [15:0] obs_data_in;
    logic [15:0] obs_data_out;
    logic        obs_wr_ack, obs_overflow, obs_underflow;
    logic        obs_full, obs_empty, obs_almostfull, obs_almostempty;
    logic        test_finished;

    logic        cmp_valid, mismatch, err_seen, done;
    logic [7:0]  mismatch_mask, first_err_mask;
    logic [31:0] correct_count, error_count;

    logic        sat_cmp_valid, sat_mismatch, sat_err_seen, sat_done;
    logic [7:0]  sat_mismatch_mask, sat_first_err_mask;
    logic [3:0]  sat_correct_count, sat_error_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_ref_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .obs_rst_n(obs_rst_n), .obs_wr_en(obs_wr_en), .obs_rd_en(obs_rd_en),
        .obs_data_in(obs_data_in), .obs_data_out(obs_data_out), .obs_wr_ack(obs_wr_ack),
        .obs_overflow(obs_overflow), .obs_underflow(obs_underflow), .obs_full(obs_full),
        .obs_empty(obs_empty), .obs_almostfull(obs_almostfull), .obs_almostempty(obs_almostempty),
        .test_finished(test_finished), .cmp_valid(cmp_valid), .mismatch(mismatch),
        .mismatch_mask(mismatch_mask), .first_err_mask(first_err_mask), .err_seen(err_seen),
        .correct_count(correct_count), .error_count(error_count), .done(done)
    );

    fifo_ref_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .obs_rst_n(obs_rst_n), .obs_wr_en(obs_wr_en), .obs_rd_en(obs_rd_en),
        .obs_data_in(obs_data_in), .obs_data_out(obs_data_out), .obs_wr_ack(obs_wr_ack),
        .obs_overflow(obs_overflow), .obs_underflow(obs_underflow), .obs_full(obs_full),
        .obs_empty(obs_empty), .obs_almostfull(obs_almostfull), .obs_almostempty(obs_almostempty),
        .test_finished(test_finished), .cmp_valid(sat_cmp_valid), .mismatch(sat_mismatch),
        .mismatch_mask(sat_mismatch_mask), .first_err_mask(sat_first_err_mask), .err_seen(sat_err_seen),
        .correct_count(sat_correct_count), .error_count(sat_error_count), .done(sat_done)
    );

    // Observed FIFO outputs as they stand after the previous edge; c is the hand-tracked occupancy.
    task automatic set_obs(input logic [15:0] dout, input logic ack, input logic ovf, input logic udf, input int c);
        obs_data_out    = dout;
        obs_wr_ack      = ack;
        obs_overflow    = ovf;
        obs_underflow   = udf;
        obs_full        = (c == 8);
        obs_empty       = (c == 0);
        obs_almostfull  = (c == 7);
        obs_almostempty = (c == 1);
    endtask

    task automatic step(input logic wr, input logic rd, input logic [15:0] din);
        obs_wr_en   = wr;
        obs_rd_en   = rd;
        obs_data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; obs_rst_n = 1'b0; test_finished = 1'b0;
        set_obs(16'h0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if ({cmp_valid, mismatch, mismatch_mask, first_err_mask, err_seen, correct_count, error_count, done} !== '0) begin n_fail++; $display("FAIL reset_outputs cmp_valid=%0b correct=%0d error=%0d done=%0b, all required 0", cmp_valid, correct_count, error_count, done); end
        rst = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (cmp_valid !== 1'b0) begin n_fail++; $display("FAIL first_edge_cmp_valid got=%0b exp=0", cmp_valid); end
        n_checks++; if (correct_count !== 32'd0) begin n_fail++; $display("FAIL first_edge_unchecked got=%0d exp=0", correct_count); end
        obs_rst_n = 1'b1;
        repeat (6) step(1'b0, 1'b0, 16'h0);
        n_checks++; if (cmp_valid !== 1'b1) begin n_fail++; $display("FAIL idle_cmp_valid got=%0b exp=1", cmp_valid); end
        n_checks++; if (correct_count !== 32'd6) begin n_fail++; $display("FAIL idle_correct got=%0d exp=6", correct_count); end
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL idle_error got=%0d exp=0", error_count); end
    endtask

    task automatic test_write();
        for (int i = 1; i <= 8; i++) begin
            set_obs(16'h0, (i > 1), 1'b0, 1'b0, i - 1);
            step(1'b1, 1'b0, 16'(i));
        end
        set_obs(16'h0, 1'b1, 1'b0, 1'b0, 8);
        step(1'b1, 1'b0, 16'h0009);
        set_obs(16'h0, 1'b0, 1'b1, 1'b0, 8);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL overflow_mismatch got=%0b exp=0", mismatch); end
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL write_error got=%0d exp=0", error_count); end
        n_checks++; if (correct_count !== 32'd16) begin n_fail++; $display("FAIL write_correct got=%0d exp=16", correct_count); end
        n_checks++; if (sat_correct_count !== 4'd15) begin n_fail++; $display("FAIL saturate_correct got=%0d exp=15", sat_correct_count); end
    endtask

    task automatic test_read();
        for (int j = 1; j <= 8; j++) begin
            set_obs(16'(j - 1), 1'b0, 1'b0, 1'b0, 9 - j);
            step(1'b0, 1'b1, 16'h0);
        end
        set_obs(16'h0008, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0);
        set_obs(16'h0008, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL read_error got=%0d exp=0", error_count); end
        n_checks++; if (correct_count !== 32'd26) begin n_fail++; $display("FAIL read_correct got=%0d exp=26", correct_count); end
    endtask

    task automatic test_simultaneous();
        set_obs(16'h0008, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 16'h00A0);
        set_obs(16'h0008, 1'b1, 1'b0, 1'b1, 1);
        step(1'b1, 1'b0, 16'h00A1);
        set_obs(16'h0008, 1'b1, 1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 16'h00A2);
        set_obs(16'h0008, 1'b1, 1'b0, 1'b0, 3);
        step(1'b1, 1'b0, 16'h00A3);
        set_obs(16'h0008, 1'b1, 1'b0, 1'b0, 4);
        step(1'b1, 1'b1, 16'h00A4);
        for (int k = 0; k < 4; k++) begin
            set_obs(16'h00A0, 1'b1, 1'b0, 1'b0, 4 + k);
            step(1'b1, 1'b0, 16'h00A5 + 16'(k));
        end
        set_obs(16'h00A0, 1'b1, 1'b0, 1'b0, 8);
        step(1'b1, 1'b1, 16'h00FF);
        set_obs(16'h00A1, 1'b0, 1'b1, 1'b0, 7);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL simul_error got=%0d exp=0", error_count); end
        n_checks++; if (correct_count !== 32'd37) begin n_fail++; $display("FAIL simul_correct got=%0d exp=37", correct_count); end
    endtask

    task automatic test_fault();
        set_obs(16'h00A1, 1'b0, 1'b0, 1'b0, 7);
        step(1'b0, 1'b1, 16'h0);
        set_obs(16'h00A2, 1'b0, 1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 16'h0);
        set_obs(16'h00A3, 1'b0, 1'b0, 1'b0, 5);
        step(1'b0, 1'b1, 16'h0);
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL pre_fault_mismatch got=%0b exp=0", mismatch); end
        set_obs(16'h00A5, 1'b0, 1'b0, 1'b0, 4);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL fault_mismatch got=%0b exp=1", mismatch); end
        n_checks++; if (mismatch_mask !== 8'h01) begin n_fail++; $display("FAIL fault_mask got=%0h exp=01", mismatch_mask); end
        n_checks++; if (first_err_mask !== 8'h01) begin n_fail++; $display("FAIL fault_first_mask got=%0h exp=01", first_err_mask); end
        n_checks++; if (error_count !== 32'd1) begin n_fail++; $display("FAIL fault_error got=%0d exp=1", error_count); end
        n_checks++; if (err_seen !== 1'b1) begin n_fail++; $display("FAIL fault_err_seen got=%0b exp=1", err_seen); end
        set_obs(16'h00A4, 1'b0, 1'b0, 1'b0, 4);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if ({mismatch, mismatch_mask} !== 9'h000) begin n_fail++; $display("FAIL fault_pulse_end got=%0b/%0h exp=0/00", mismatch, mismatch_mask); end
        n_checks++; if (first_err_mask !== 8'h01) begin n_fail++; $display("FAIL first_mask_sticky got=%0h exp=01", first_err_mask); end
        n_checks++; if (correct_count !== 32'd41) begin n_fail++; $display("FAIL fault_correct got=%0d exp=41", correct_count); end
        n_checks++; if ({sat_correct_count, sat_error_count} !== {4'd15, 4'd1}) begin n_fail++; $display("FAIL sat_counts got=%0d/%0d exp=15/1", sat_correct_count, sat_error_count); end
    endtask

    task automatic test_finish_and_reset();
        set_obs(16'h00A4, 1'b0, 1'b0, 1'b0, 4);
        obs_full = 1'b1;
        test_finished = 1'b1;
        step(1'b1, 1'b0, 16'h00A9);
        n_checks++; if (error_count !== 32'd2) begin n_fail++; $display("FAIL finish_edge_error got=%0d exp=2", error_count); end
        n_checks++; if (mismatch_mask !== 8'h10) begin n_fail++; $display("FAIL finish_edge_mask got=%0h exp=10", mismatch_mask); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_set got=%0b exp=1", done); end
        test_finished = 1'b0;
        set_obs(16'h00A4, 1'b1, 1'b0, 1'b0, 5);
        obs_empty = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got=%0b exp=1", done); end
        n_checks++; if ({error_count, correct_count} !== {32'd2, 32'd41}) begin n_fail++; $display("FAIL frozen_counts got=%0d/%0d exp=2/41", error_count, correct_count); end
        n_checks++; if ({mismatch_mask, first_err_mask} !== 16'h1001) begin n_fail++; $display("FAIL frozen_masks got=%0h/%0h exp=10/01", mismatch_mask, first_err_mask); end
        set_obs(16'h00A4, 1'b0, 1'b0, 1'b0, 5);
        rst = 1'b1;
        test_finished = 1'b1;
        step(1'b1, 1'b0, 16'h00AA);
        n_checks++; if ({cmp_valid, mismatch, mismatch_mask, first_err_mask, err_seen, correct_count, error_count, done} !== '0) begin n_fail++; $display("FAIL midburst_reset correct=%0d error=%0d done=%0b, all required 0", correct_count, error_count, done); end
        n_checks++; if ({sat_cmp_valid, sat_mismatch, sat_mismatch_mask, sat_first_err_mask, sat_err_seen, sat_correct_count, sat_error_count, sat_done} !== '0) begin n_fail++; $display("FAIL midburst_reset_sat correct=%0d error=%0d, all required 0", sat_correct_count, sat_error_count); end
        rst = 1'b0;
        test_finished = 1'b0;
        set_obs(16'h0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        n_checks++; if ({correct_count, error_count} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL model_cleared got=%0d/%0d exp=1/0", correct_count, error_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_fault();
        test_finish_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
